// File: rtl/imem_stream_prefetch.sv
// I-cache to slow-memory bridge: forwards line reads/writes and, after each demand read,
// prefetches the next sequential line into a one-line stream buffer.
module imem_stream_prefetch #(
    parameter int ADDR_W    = 28,
    parameter int LINE_W    = 128,
    parameter int PF_ENABLE = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              cache_read,
    input  logic              cache_write,
    input  logic [ADDR_W-1:0] cache_addr,
    input  logic [LINE_W-1:0] cache_wdata,
    output logic [LINE_W-1:0] cache_rdata,
    output logic              cache_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  pf_hits
);

    localparam bit PF_ON = (PF_ENABLE != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIT_RESP,
        S_DEMAND,
        S_DEMAND_RESP,
        S_WRITE,
        S_WRITE_RESP,
        S_PREFETCH
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] buf_tag;
    logic [LINE_W-1:0] buf_data;
    logic              buf_valid;
    logic              buf_hit;
    logic [ADDR_W-1:0] pf_addr;

    assign buf_hit = buf_valid && (buf_tag == cache_addr);

    // Next line after the one just returned; wraps modulo 2^ADDR_W.
    assign pf_addr = ((state == S_HIT_RESP) ? buf_tag : mem_addr) + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (proc_reset) state <= S_IDLE;
        else            state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        state_next  = state;
        cache_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (cache_write)     state_next = S_WRITE;
                else if (cache_read) state_next = buf_hit ? S_HIT_RESP : S_DEMAND;
            end
            S_HIT_RESP: begin
                cache_ready = 1'b1;
                state_next  = PF_ON ? S_PREFETCH : S_IDLE;
            end
            S_DEMAND: begin
                if (mem_ready) state_next = S_DEMAND_RESP;
            end
            S_DEMAND_RESP: begin
                cache_ready = 1'b1;
                state_next  = PF_ON ? S_PREFETCH : S_IDLE;
            end
            S_WRITE: begin
                if (mem_ready) state_next = S_WRITE_RESP;
            end
            S_WRITE_RESP: begin
                cache_ready = 1'b1;
                state_next  = S_IDLE;
            end
            S_PREFETCH: begin
                if (mem_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cache_rdata <= '0;
            pf_hits     <= '0;
            buf_valid   <= 1'b0;
            buf_tag     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cache_write) begin
                        mem_write <= 1'b1;
                        mem_addr  <= cache_addr;
                        mem_wdata <= cache_wdata;
                        if (buf_tag == cache_addr) buf_valid <= 1'b0;
                    end else if (cache_read) begin
                        if (buf_hit) begin
                            cache_rdata <= buf_data;
                        end else begin
                            mem_read <= 1'b1;
                            mem_addr <= cache_addr;
                        end
                    end
                end
                S_HIT_RESP: begin
                    if (pf_hits != '1) pf_hits <= pf_hits + CNT_W'(1);
                end
                S_DEMAND: begin
                    if (mem_ready) begin
                        mem_read    <= 1'b0;
                        cache_rdata <= mem_rdata;
                    end
                end
                S_WRITE: begin
                    if (mem_ready) mem_write <= 1'b0;
                end
                S_PREFETCH: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        buf_tag   <= mem_addr;
                        buf_valid <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Leaving a read response launches the sequential prefetch and retires the old line.
            if (PF_ON && ((state == S_HIT_RESP) || (state == S_DEMAND_RESP))) begin
                mem_read  <= 1'b1;
                mem_addr  <= pf_addr;
                buf_valid <= 1'b0;
            end
        end
    end

    // NOTE: buffer payload is left unreset; buf_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if ((state == S_PREFETCH) && mem_ready) buf_data <= mem_rdata;
    end

endmodule

// File: tb/tb_imem_stream_prefetch.sv
// Scoreboard bench: stimulus pushes expected memory requests and cache responses into queues;
// a negedge monitor pops and compares them. A second instance covers PF_ENABLE=0.
module tb_imem_stream_prefetch;

    localparam int AW      = 28;
    localparam int LW      = 128;
    localparam int CW      = 16;
    localparam int MEM_LAT = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          proc_reset;
    logic          sel;
    logic          c_read, c_write;
    logic [AW-1:0] c_addr;
    logic [LW-1:0] c_wdata;
    logic          m_ready;
    logic [LW-1:0] m_rdata;

    logic          read_p, write_p, read_n, write_n;
    logic          mready_p, mready_n;
    logic [LW-1:0] rdata_p, rdata_n, mwdata_p, mwdata_n;
    logic          ready_p, ready_n, mread_p, mread_n, mwrite_p, mwrite_n;
    logic [AW-1:0] maddr_p, maddr_n;
    logic [CW-1:0] pf_hits_p, pf_hits_n;

    assign read_p   = c_read & ~sel;
    assign write_p  = c_write & ~sel;
    assign read_n   = c_read & sel;
    assign write_n  = c_write & sel;
    assign mready_p = m_ready & ~sel;
    assign mready_n = m_ready & sel;

    imem_stream_prefetch #(.ADDR_W(AW), .LINE_W(LW), .PF_ENABLE(1), .CNT_W(CW)) u_dut (
        .clk(clk), .proc_reset(proc_reset),
        .cache_read(read_p), .cache_write(write_p), .cache_addr(c_addr), .cache_wdata(c_wdata),
        .cache_rdata(rdata_p), .cache_ready(ready_p),
        .mem_read(mread_p), .mem_write(mwrite_p), .mem_addr(maddr_p), .mem_wdata(mwdata_p),
        .mem_rdata(m_rdata), .mem_ready(mready_p), .pf_hits(pf_hits_p)
    );

    imem_stream_prefetch #(.ADDR_W(AW), .LINE_W(LW), .PF_ENABLE(0), .CNT_W(CW)) u_dut_np (
        .clk(clk), .proc_reset(proc_reset),
        .cache_read(read_n), .cache_write(write_n), .cache_addr(c_addr), .cache_wdata(c_wdata),
        .cache_rdata(rdata_n), .cache_ready(ready_n),
        .mem_read(mread_n), .mem_write(mwrite_n), .mem_addr(maddr_n), .mem_wdata(mwdata_n),
        .mem_rdata(m_rdata), .mem_ready(mready_n), .pf_hits(pf_hits_n)
    );

    logic          mon_c_ready, mon_mread, mon_mwrite;
    logic [LW-1:0] mon_c_rdata, mon_mwdata;
    logic [AW-1:0] mon_maddr;
    assign mon_c_ready = sel ? ready_n  : ready_p;
    assign mon_c_rdata = sel ? rdata_n  : rdata_p;
    assign mon_mread   = sel ? mread_n  : mread_p;
    assign mon_mwrite  = sel ? mwrite_n : mwrite_p;
    assign mon_maddr   = sel ? maddr_n  : maddr_p;
    assign mon_mwdata  = sel ? mwdata_n : mwdata_p;

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } mreq_t;

    typedef struct {
        logic          is_wr;
        logic [LW-1:0] data;
        int            dly;
    } cresp_t;

    mreq_t  mq[$];
    cresp_t cq[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;

    localparam logic [LW-1:0] W1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [LW-1:0] W2 = 128'h11112222_33334444_55556666_77778888;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
        mreq_t e;
        e.is_wr = wr; e.addr = addr; e.wdata = wdata;
        mq.push_back(e);
    endtask

    task automatic exp_resp(input logic wr, input logic [LW-1:0] data, input int dly);
        cresp_t r;
        r.is_wr = wr; r.data = data; r.dly = dly;
        cq.push_back(r);
    endtask

    // Holds the request until cache_ready; exp_waits counts negedges from issue (0 = unchecked).
    task automatic cache_op(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                            input int exp_waits, input string name);
        int waits = 0;
        bit done = 0;
        @(posedge clk); #1;
        c_write = wr; c_read = ~wr; c_addr = addr; c_wdata = wdata;
        while (!done && waits < 200) begin
            @(negedge clk);
            waits++;
            if (mon_c_ready) done = 1;
        end
        check({name, "_done"}, LW'(done), LW'(1));
        if (done && exp_waits > 0) check({name, "_latency"}, LW'(waits), LW'(exp_waits));
        @(posedge clk); #1;
        c_read = 1'b0; c_write = 1'b0;
    endtask

    task automatic wait_mem_idle(input string name);
        bit idle = 0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge clk);
            if (!mon_mread && !mon_mwrite && !m_ready) idle = 1;
        end
        check({name, "_idle"}, LW'(idle), LW'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cache_ready"}, LW'(ready_p), '0);
        check({tag, "_cache_rdata"}, rdata_p, '0);
        check({tag, "_mem_read"}, LW'(mread_p), '0);
        check({tag, "_mem_write"}, LW'(mwrite_p), '0);
        check({tag, "_mem_addr"}, LW'(maddr_p), '0);
        check({tag, "_mem_wdata"}, mwdata_p, '0);
        check({tag, "_pf_hits"}, LW'(pf_hits_p), '0);
    endtask

    function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
        return {4{4'hA, a}};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slow memory: answers MEM_LAT cycles after a request appears, drops it if the request vanishes.
    initial begin : mem_model
        bit ok;
        m_ready = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mon_mread || mon_mwrite) begin
                ok = 1;
                for (int i = 1; i < MEM_LAT; i++) begin
                    @(posedge clk); #1;
                    if (!(mon_mread || mon_mwrite)) begin
                        ok = 0;
                        break;
                    end
                end
                if (ok) begin
                    m_rdata = mem_line(mon_maddr);
                    m_ready = 1'b1;
                    @(posedge clk); #1;
                    m_ready = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        logic          req, prev_req;
        logic [AW-1:0] prev_addr;
        logic [LW-1:0] prev_wdata;
        int            last_rdy_cyc;
        mreq_t         e;
        cresp_t        r;
        prev_req = 1'b0; prev_addr = '0; prev_wdata = '0; last_rdy_cyc = -100;
        forever begin
            @(negedge clk);
            if (m_ready) last_rdy_cyc = cyc;
            req = mon_mread | mon_mwrite;
            if (req && !prev_req) begin
                check("mem_rw_exclusive", LW'(mon_mread & mon_mwrite), '0);
                if (mq.size() == 0) begin
                    check("mem_unexpected_addr", LW'(mon_maddr), LW'(1) << 100);
                end else begin
                    e = mq.pop_front();
                    check("mem_kind", LW'(mon_mwrite), LW'(e.is_wr));
                    check("mem_addr", LW'(mon_maddr), LW'(e.addr));
                    if (e.is_wr) check("mem_wdata", mon_mwdata, e.wdata);
                end
            end else if (req && prev_req) begin
                check("mem_addr_stable", LW'(mon_maddr), LW'(prev_addr));
                check("mem_wdata_stable", mon_mwdata, prev_wdata);
            end
            prev_req = req; prev_addr = mon_maddr; prev_wdata = mon_mwdata;

            if (mon_c_ready) begin
                if (cq.size() == 0) begin
                    check("cache_ready_unexpected", LW'(mon_c_ready), '0);
                end else begin
                    r = cq.pop_front();
                    if (!r.is_wr) check("cache_rdata", mon_c_rdata, r.data);
                    if (r.dly > 0) check("cache_ready_after_mem_ready", LW'(cyc - last_rdy_cyc), LW'(r.dly));
                end
            end
        end
    end

    initial begin
        proc_reset = 1'b1; sel = 1'b0;
        c_read = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset_np_pf_hits", LW'(pf_hits_n), '0);
        @(posedge clk); #1;
        proc_reset = 1'b0;

        // Demand miss then prefetch of the next line
        exp_mem(0, 28'h0000010, '0);
        exp_mem(0, 28'h0000011, '0);
        exp_resp(0, 128'hA0000010_A0000010_A0000010_A0000010, 1);
        cache_op(0, 28'h0000010, '0, MEM_LAT + 2, "miss_0x10");
        wait_mem_idle("pf_0x11");

        // Buffer hit: no memory read for 0x11, next-line prefetch of 0x12
        exp_mem(0, 28'h0000012, '0);
        exp_resp(0, 128'hA0000011_A0000011_A0000011_A0000011, 0);
        cache_op(0, 28'h0000011, '0, 2, "hit_0x11");
        check("pf_hits_after_0x11", LW'(pf_hits_p), LW'(1));

        // Read of the line currently being prefetched
        exp_mem(0, 28'h0000013, '0);
        exp_resp(0, 128'hA0000012_A0000012_A0000012_A0000012, 2);
        cache_op(0, 28'h0000012, '0, 0, "hit_inflight_0x12");
        check("pf_hits_after_0x12", LW'(pf_hits_p), LW'(2));
        wait_mem_idle("pf_0x13");

        // Write to the buffered line invalidates it
        exp_mem(1, 28'h0000013, W1);
        exp_resp(1, '0, 1);
        cache_op(1, 28'h0000013, W1, MEM_LAT + 2, "write_0x13");
        exp_mem(0, 28'h0000013, '0);
        exp_mem(0, 28'h0000014, '0);
        exp_resp(0, 128'hA0000013_A0000013_A0000013_A0000013, 1);
        cache_op(0, 28'h0000013, '0, MEM_LAT + 2, "miss_after_write_0x13");
        check("pf_hits_after_write", LW'(pf_hits_p), LW'(2));
        wait_mem_idle("pf_0x14");

        // Write elsewhere leaves the buffer intact
        exp_mem(1, 28'h0000050, W2);
        exp_resp(1, '0, 1);
        cache_op(1, 28'h0000050, W2, MEM_LAT + 2, "write_0x50");
        exp_mem(0, 28'h0000015, '0);
        exp_resp(0, 128'hA0000014_A0000014_A0000014_A0000014, 0);
        cache_op(0, 28'h0000014, '0, 2, "hit_0x14");
        check("pf_hits_after_0x14", LW'(pf_hits_p), LW'(3));
        wait_mem_idle("pf_0x15");

        // Top line: prefetch wraps to 0, then reset abandons it
        exp_mem(0, 28'hFFFFFFF, '0);
        exp_mem(0, 28'h0000000, '0);
        exp_resp(0, 128'hAFFFFFFF_AFFFFFFF_AFFFFFFF_AFFFFFFF, 1);
        cache_op(0, 28'hFFFFFFF, '0, MEM_LAT + 2, "miss_0xfffffff");
        check("pf_wrap_mem_read", LW'(mread_p), LW'(1));
        check("pf_wrap_mem_addr", LW'(maddr_p), '0);
        @(posedge clk); #1;
        proc_reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset");
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        proc_reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset_no_ready", LW'(ready_p), '0);

        // Buffer empty after reset: line 0 must come from memory
        exp_mem(0, 28'h0000000, '0);
        exp_mem(0, 28'h0000001, '0);
        exp_resp(0, 128'hA0000000_A0000000_A0000000_A0000000, 1);
        cache_op(0, 28'h0000000, '0, MEM_LAT + 2, "miss_after_reset_0x0");
        wait_mem_idle("pf_0x1");

        // Prefetch disabled instance
        @(posedge clk); #1;
        sel = 1'b1;
        exp_mem(0, 28'h0000020, '0);
        exp_resp(0, 128'hA0000020_A0000020_A0000020_A0000020, 1);
        cache_op(0, 28'h0000020, '0, MEM_LAT + 2, "np_miss_0x20");
        exp_mem(0, 28'h0000021, '0);
        exp_resp(0, 128'hA0000021_A0000021_A0000021_A0000021, 1);
        cache_op(0, 28'h0000021, '0, MEM_LAT + 2, "np_miss_0x21");
        repeat (10) @(negedge clk);
        check("np_pf_hits", LW'(pf_hits_n), '0);
        check("np_no_traffic", LW'(mread_n | mwrite_n), '0);

        check("mem_queue_drained", LW'(mq.size()), '0);
        check("resp_queue_drained", LW'(cq.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
